array_b_tile_addr_gen: RTL

//   Generates the B-matrix buffer read addresses that feed the systolic array, one per beat.

---
 rtl/matrix_mult_pkg.sv | 25 ++
 rtl/array_b_tile_addr_gen_wrap_counter.sv | 33 +++
 rtl/array_b_tile_addr_gen.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/matrix_mult_pkg.sv
// Shared types and default geometry for the matrix-multiply address generators.
// Contents:
//   dim_t         - matrix dimension / loop counter type
//   agen_state_e  - address generator FSM states
//   DEF_*         - default array geometry and widths
//   LOG2_DEF_*    - shift amounts for ceil-tiling by the default array size
package matrix_mult_pkg;

  localparam int DEF_ARRAY_HEIGHT = 4;
  localparam int DEF_ARRAY_WIDTH  = 4;
  localparam int DEF_ADDR_WIDTH   = 10;
  localparam int DIM_WIDTH        = 16;

  localparam int LOG2_DEF_ARRAY_HEIGHT = $clog2(DEF_ARRAY_HEIGHT);
  localparam int LOG2_DEF_ARRAY_WIDTH  = $clog2(DEF_ARRAY_WIDTH);

  typedef logic [DIM_WIDTH-1:0] dim_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } agen_state_e;

endpackage

// File: rtl/array_b_tile_addr_gen_wrap_counter.sv
// Up-counter that wraps to zero after reaching limit-1.
// Ports:
//   clk, reset_n  clock, async active-low reset
//   limit         number of counts per wrap (must be nonzero while counting)
//   inc           advance by one this cycle
//   clr           synchronous clear, wins over inc
//   count         current value
//   wrap          inc is advancing from limit-1 back to zero this cycle
module wrap_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] limit,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  assign wrap = inc && (count == limit - WIDTH'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/array_b_tile_addr_gen.sv
// B-matrix buffer read address generator for the systolic array.
// Walks k (innermost), column tile, row tile over C = A(m x n) * B(n x p) and
// emits addr = base + k*row_stride + ct, one beat per valid/ready transfer.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   start_i, abort_i      run control
//   m_i, n_i, p_i         dimensions, sampled when start is accepted
//   base_addr_i           address of B(0, tile 0), sampled at start
//   row_stride_i          words between consecutive k rows, sampled at start
//   addr_o/addr_valid_o   read address stream, addr_ready_i is the back-pressure
//   last_k_o              beat is the last k of its column tile
//   lane_mask_o           active PE columns (only when B_LANE_MASK_EN is defined)
//   busy_o, done_o, err_o status; done_o and err_o are single-cycle pulses
// Optional feature macro: B_LANE_MASK_EN
//
// state | meaning
// IDLE  | waiting for start; rejected starts pulse err_o
// RUN   | presenting addresses, valid held high
// DONE  | single cycle after the final beat, done_o high
module array_b_tile_addr_gen
  import matrix_mult_pkg::*;
#(
  parameter int ARRAY_HEIGHT         = DEF_ARRAY_HEIGHT,
  parameter int ARRAY_WIDTH          = DEF_ARRAY_WIDTH,
  parameter int BUFFER_ADDRESS_WIDTH = DEF_ADDR_WIDTH,
  parameter int DIM_WIDTH            = matrix_mult_pkg::DIM_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start_i,
  input  logic                            abort_i,
  input  logic [DIM_WIDTH-1:0]            m_i,
  input  logic [DIM_WIDTH-1:0]            n_i,
  input  logic [DIM_WIDTH-1:0]            p_i,
  input  logic [BUFFER_ADDRESS_WIDTH-1:0] base_addr_i,
  input  logic [BUFFER_ADDRESS_WIDTH-1:0] row_stride_i,
  output logic [BUFFER_ADDRESS_WIDTH-1:0] addr_o,
  output logic                            addr_valid_o,
  input  logic                            addr_ready_i,
  output logic                            last_k_o,
`ifdef B_LANE_MASK_EN
  output logic [ARRAY_WIDTH-1:0]          lane_mask_o,
`endif
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            err_o
);

  localparam int AW     = BUFFER_ADDRESS_WIDTH;
  localparam int CW     = DIM_WIDTH + 1;
  localparam int LOG2_W = $clog2(ARRAY_WIDTH);
  localparam int LOG2_H = $clog2(ARRAY_HEIGHT);

  agen_state_e state, state_next;
  logic load, xfer, err_next, dims_ok;

  logic [DIM_WIDTH-1:0] n_q, k_count;
  logic [CW-1:0]        ct_lim_q, rt_lim_q, ct_count, rt_count, ct_lim_d, rt_lim_d;
  logic [AW-1:0]        base_q, stride_q, addr_q, col_q;
  logic                 k_wrap, ct_wrap, rt_wrap;
  logic                 unused_ok;

  assign dims_ok  = (|m_i) && (|n_i) && (|p_i);
  // Ceil tiling evaluated one bit wider than the dimensions so p near 2^DIM_WIDTH cannot overflow.
  assign ct_lim_d = (CW'(p_i) + CW'(ARRAY_WIDTH - 1)) >> LOG2_W;
  assign rt_lim_d = (CW'(m_i) + CW'(ARRAY_HEIGHT - 1)) >> LOG2_H;
  // Abort takes priority over a same-cycle transfer.
  assign xfer     = (state == RUN) && addr_ready_i && !abort_i;

  always_comb begin
    state_next = state;
    load       = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          if (dims_ok) begin
            load       = 1'b1;
            state_next = RUN;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort_i)      state_next = IDLE;
        else if (rt_wrap) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      err_o    <= 1'b0;
      n_q      <= '0;
      ct_lim_q <= '0;
      rt_lim_q <= '0;
      base_q   <= '0;
      stride_q <= '0;
      addr_q   <= '0;
      col_q    <= '0;
    end else begin
      state <= state_next;
      err_o <= err_next;
      if (load) begin
        n_q      <= n_i;
        ct_lim_q <= ct_lim_d;
        rt_lim_q <= rt_lim_d;
        base_q   <= base_addr_i;
        stride_q <= row_stride_i;
        addr_q   <= base_addr_i;
        col_q    <= base_addr_i;
      end else if (xfer) begin
        // col_q tracks base + ct so each new column tile restarts its k walk without a multiply.
        if (!k_wrap) begin
          addr_q <= addr_q + stride_q;
        end else if (!ct_wrap) begin
          col_q  <= col_q + AW'(1);
          addr_q <= col_q + AW'(1);
        end else begin
          col_q  <= base_q;
          addr_q <= base_q;
        end
      end
    end
  end

  wrap_counter #(.WIDTH(DIM_WIDTH)) u_k_cnt (
    .clk(clk), .reset_n(reset_n), .limit(n_q), .inc(xfer), .clr(load),
    .count(k_count), .wrap(k_wrap)
  );

  wrap_counter #(.WIDTH(CW)) u_ct_cnt (
    .clk(clk), .reset_n(reset_n), .limit(ct_lim_q), .inc(k_wrap), .clr(load),
    .count(ct_count), .wrap(ct_wrap)
  );

  wrap_counter #(.WIDTH(CW)) u_rt_cnt (
    .clk(clk), .reset_n(reset_n), .limit(rt_lim_q), .inc(ct_wrap), .clr(load),
    .count(rt_count), .wrap(rt_wrap)
  );

  assign addr_valid_o = (state == RUN);
  assign busy_o       = (state != IDLE);
  assign done_o       = (state == DONE);
  assign addr_o       = addr_valid_o ? addr_q : '0;
  assign last_k_o     = addr_valid_o && (k_count == n_q - DIM_WIDTH'(1));

`ifdef B_LANE_MASK_EN
  logic [ARRAY_WIDTH-1:0] last_mask_q;
  logic [DIM_WIDTH-1:0]   p_rem;

  // Lanes used by the final column tile; a remainder of zero means the tile is full.
  assign p_rem = p_i & DIM_WIDTH'(ARRAY_WIDTH - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_mask_q <= '0;
    end else if (load) begin
      for (int i = 0; i < ARRAY_WIDTH; i++) begin
        last_mask_q[i] <= (p_rem == '0) || (DIM_WIDTH'(i) < p_rem);
      end
    end
  end

  assign lane_mask_o = !addr_valid_o                     ? '0          :
                       (ct_count == ct_lim_q - CW'(1))   ? last_mask_q : '1;
`endif

  assign unused_ok = ^{rt_count, ct_count};

endmodule
